// File: rtl/spi_rom_reader_if.sv
// rtl/spi_rom_reader_if.sv - request, byte-stream and SPI pin bundle for spi_rom_reader
interface spi_rom_reader_if;
    logic        start;
    logic [23:0] addr;
    logic        abort;
    logic        busy;
    logic        done;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        spi_cs;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_miso;

    modport master (
        output start, addr, abort, spi_miso,
        input  busy, done, data_out, data_valid, spi_cs, spi_sclk, spi_mosi
    );

    modport slave (
        input  start, addr, abort, spi_miso,
        output busy, done, data_out, data_valid, spi_cs, spi_sclk, spi_mosi
    );
endinterface

// File: rtl/spi_rom_reader.sv
// rtl/spi_rom_reader.sv - SPI mode-0 burst reader for serial flash; FAST_READ_EN selects 0x0B + dummy byte
module spi_rom_reader #(
    parameter int unsigned BURST_BYTES = 16,
    parameter logic [7:0]  CMD_READ    = 8'h03,
    parameter logic [7:0]  CMD_FAST    = 8'h0B
) (
    input  logic            clk,
    input  logic            reset_n,
    spi_rom_reader_if.slave bus
);

`ifdef FAST_READ_EN
    localparam int unsigned HDR_BITS = 40;
    localparam logic [7:0]  CMD      = CMD_FAST;
`else
    localparam int unsigned HDR_BITS = 32;
    localparam logic [7:0]  CMD      = CMD_READ;
`endif

    // Sized for the worst case of 40 header bits plus 255 data bytes.
    localparam int unsigned      CNT_W    = 12;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(HDR_BITS + 8 * BURST_BYTES - 1);
    localparam logic [CNT_W-1:0] CMD_END  = CNT_W'(8);
    localparam logic [CNT_W-1:0] ADDR_END = CNT_W'(32);
`ifdef FAST_READ_EN
    localparam logic [CNT_W-1:0] DUMMY_END = CNT_W'(40);
`endif

    typedef enum logic [2:0] {
        IDLE,
        CMD_S,
        ADDR_S,
`ifdef FAST_READ_EN
        DUMMY_S,
`endif
        DATA_S
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             sclk_q, sclk_d;
    logic             cs_q, cs_d;
    logic             mosi_q, mosi_d;
    logic [31:0]      tx_q, tx_d;
    logic [7:0]       rx_q, rx_d;
    logic [7:0]       data_q, data_d;
    logic             dv_q, dv_d;
    logic             done_q, done_d;

    logic [7:0]       rx_next;
    logic [CNT_W-1:0] cnt_inc;
    logic             byte_end;

    function automatic state_t phase_of(input logic [CNT_W-1:0] n);
        state_t s;
        s = DATA_S;
`ifdef FAST_READ_EN
        if (n < DUMMY_END) s = DUMMY_S;
`endif
        if (n < ADDR_END) s = ADDR_S;
        if (n < CMD_END)  s = CMD_S;
        return s;
    endfunction

    assign rx_next  = {rx_q[6:0], bus.spi_miso};
    assign cnt_inc  = bit_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    assign byte_end = (state_q == DATA_S) && (bit_cnt_q[2:0] == 3'd7);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sclk_d    = sclk_q;
        cs_d      = cs_q;
        mosi_d    = mosi_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        data_d    = data_q;
        dv_d      = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = CMD_S;
                    bit_cnt_d = '0;
                    cs_d      = 1'b1;
                    sclk_d    = 1'b0;
                    mosi_d    = CMD[7];
                    // Zeros shift in behind the address, so mosi idles low for dummy/data bits.
                    tx_d      = {CMD[6:0], bus.addr, 1'b0};
                end
            end
            default: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    cs_d    = 1'b0;
                    sclk_d  = 1'b0;
                    mosi_d  = 1'b0;
                end else if (!sclk_q) begin
                    sclk_d = 1'b1;
                end else begin
                    // End of high phase: sample miso and move mosi on to the next bit.
                    sclk_d = 1'b0;
                    rx_d   = rx_next;
                    if (byte_end) begin
                        data_d = rx_next;
                        dv_d   = 1'b1;
                    end
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = IDLE;
                        cs_d    = 1'b0;
                        mosi_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        bit_cnt_d = cnt_inc;
                        state_d   = phase_of(cnt_inc);
                        mosi_d    = tx_q[31];
                        tx_d      = {tx_q[30:0], 1'b0};
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b0;
            mosi_q    <= 1'b0;
            tx_q      <= '0;
            rx_q      <= '0;
            data_q    <= '0;
            dv_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sclk_q    <= sclk_d;
            cs_q      <= cs_d;
            mosi_q    <= mosi_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            data_q    <= data_d;
            dv_q      <= dv_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;
    assign bus.data_out   = data_q;
    assign bus.data_valid = dv_q;
    assign bus.spi_cs     = cs_q;
    assign bus.spi_sclk   = sclk_q;
    assign bus.spi_mosi   = mosi_q;

endmodule

// File: tb/tb_spi_rom_reader.sv
// tb/tb_spi_rom_reader.sv - directed vector bench for spi_rom_reader with a behavioural SPI flash
`timescale 1ns/1ps
module tb_spi_rom_reader;

`ifdef FAST_READ_EN
    localparam int         HDR      = 40;
    localparam logic [7:0] CMD      = 8'h0B;
    localparam int         FIRST_DV = 97;
`else
    localparam int         HDR      = 32;
    localparam logic [7:0] CMD      = 8'h03;
    localparam int         FIRST_DV = 81;
`endif
    localparam int NB        = 16;
    localparam int BURST_CYC = 2 * (HDR + 8 * NB) + 1;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] cmd_v   = CMD;

    always #5 clk = ~clk;

    spi_rom_reader_if bus ();

    spi_rom_reader dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] resp(input int j);
        if (j == 0) return 8'hA5;
        if (j == 1) return 8'h3C;
        return 8'((j * 37 + 11) & 255);
    endfunction

    // Flash: counts sclk rising edges since cs rose and presents the data bit during the high phase.
    int fl_k = 0;
    always @(posedge bus.spi_sclk or posedge bus.spi_cs) begin : flash_model
        logic [7:0] r;
        if (bus.spi_sclk) begin
            if (fl_k >= HDR) begin
                r = resp((fl_k - HDR) / 8);
                bus.spi_miso = r[7 - ((fl_k - HDR) % 8)];
            end else begin
                bus.spi_miso = 1'b0;
            end
            fl_k = fl_k + 1;
        end else begin
            fl_k = 0;
        end
    end

    typedef struct {
        logic [23:0] addr;
        int          poke_cyc;
        int          abort_cyc;
        int          exp_valids;
        int          exp_done;
    } vec_t;

    vec_t vecs [7];

    task automatic run_row(input vec_t v, input string tag);
        logic [47:0] cap;
        logic [47:0] eh;
        int nval, ndone, done_cyc, last_dv, bad_pat;
        cap = '0; nval = 0; ndone = 0; done_cyc = -1; last_dv = -1; bad_pat = 0;
        @(negedge clk);
        bus.addr  = v.addr;
        bus.start = 1'b1;
        bus.abort = (v.abort_cyc == 0);
        for (int cyc = 1; cyc <= BURST_CYC + 3; cyc++) begin
            @(negedge clk);
            if (cyc == 1)
                check({tag, " accept"}, 64'({bus.busy, bus.spi_cs, bus.spi_sclk, bus.spi_mosi}),
                      64'({1'b1, 1'b1, 1'b0, cmd_v[7]}));
            if (bus.spi_cs) begin
                if (bus.spi_sclk !== ((cyc % 2) == 0)) bad_pat++;
                if ((cyc - 1) / 2 >= 32 && bus.spi_mosi !== 1'b0) bad_pat++;
                if ((cyc % 2) == 0 && (cyc - 2) / 2 < HDR) cap = {cap[46:0], bus.spi_mosi};
            end
            if (bus.data_valid) begin
                check({tag, " dv_cycle"}, 64'(cyc), 64'(FIRST_DV + 16 * nval));
                check({tag, " dv_data"}, 64'(bus.data_out), 64'(resp(nval)));
                last_dv = cyc;
                nval++;
            end
            if (bus.done) begin
                ndone++;
                done_cyc = cyc;
            end
            if (v.abort_cyc > 0 && cyc == v.abort_cyc + 1)
                check({tag, " abort_idle"}, 64'({bus.busy, bus.spi_cs, bus.spi_sclk}), 64'(0));
            bus.start = (cyc == v.poke_cyc);
            if (cyc == v.poke_cyc) bus.addr = 24'hFFFFFF;
            else if (cyc == 1) bus.addr = 24'h000000;
            bus.abort = (cyc == v.abort_cyc);
        end
        if (v.abort_cyc <= 0 || v.abort_cyc > 2 * HDR + 2) begin
            eh = {16'h0000, cmd_v, v.addr};
            eh = eh << (HDR - 32);
            check({tag, " mosi_header"}, 64'(cap), 64'(eh));
        end
        check({tag, " valid_count"}, 64'(nval), 64'(v.exp_valids));
        check({tag, " done_count"}, 64'(ndone), 64'(v.exp_done));
        if (v.exp_done != 0) begin
            check({tag, " done_cycle"}, 64'(done_cyc), 64'(BURST_CYC));
            check({tag, " done_with_last"}, 64'(done_cyc), 64'(last_dv));
        end
        check({tag, " sclk_mosi_pattern"}, 64'(bad_pat), 64'(0));
        check({tag, " idle_after"}, 64'({bus.busy, bus.spi_cs, bus.spi_sclk}), 64'(0));
    endtask

    initial begin
        int bad, low, nd, ndv;
        bus.start = 1'b0;
        bus.addr  = 24'h0;
        bus.abort = 1'b0;

        vecs[0] = '{24'h123456, -1, -1, 16, 1};
        vecs[1] = '{24'h123456, 30, -1, 16, 1};
        vecs[2] = '{24'h000100, -1, FIRST_DV + 39, 3, 0};
        vecs[3] = '{24'h000000, -1, -1, 16, 1};
        vecs[4] = '{24'hABCDEF, -1, 0, 16, 1};
        vecs[5] = '{24'h5A5A5A, FIRST_DV + 39, FIRST_DV + 39, 3, 0};
        vecs[6] = '{24'h00FF00, -1, 5, 0, 0};

        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({bus.busy, bus.done, bus.data_valid, bus.data_out,
                                    bus.spi_cs, bus.spi_sclk, bus.spi_mosi}), 64'(0));
        reset_n = 1'b1;

        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.spi_cs || bus.spi_sclk || bus.busy) bad++;
            bus.abort = (i >= 3 && i <= 5);
        end
        bus.abort = 1'b0;
        check("idle_quiet", 64'(bad), 64'(0));

        foreach (vecs[i]) run_row(vecs[i], $sformatf("row%0d", i));

        // Start held high: bursts run back to back with one cs-low cycle between them.
        @(negedge clk);
        bus.addr  = 24'h000040;
        bus.start = 1'b1;
        low = 0; nd = 0; ndv = 0;
        for (int cyc = 1; cyc <= 2 * BURST_CYC + 2; cyc++) begin
            @(negedge clk);
            if (cyc == 1 || cyc == BURST_CYC + 1)
                check($sformatf("b2b cs_up_%0d", cyc), 64'(bus.spi_cs), 64'(1));
            if (cyc < 2 * BURST_CYC && !bus.spi_cs) low++;
            if (bus.done) begin
                check($sformatf("b2b done_cycle_%0d", nd), 64'(cyc), 64'((nd + 1) * BURST_CYC));
                nd++;
            end
            if (bus.data_valid) ndv++;
            if (cyc == BURST_CYC + 50) bus.start = 1'b0;
        end
        check("b2b cs_low_cycles", 64'(low), 64'(1));
        check("b2b done_count", 64'(nd), 64'(2));
        check("b2b valid_count", 64'(ndv), 64'(2 * NB));
        check("b2b idle_after", 64'({bus.busy, bus.spi_cs}), 64'(0));

        // Asynchronous reset in the middle of the address phase.
        @(negedge clk);
        bus.addr  = 24'h777777;
        bus.start = 1'b1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        check("mid_addr_active", 64'({bus.busy, bus.spi_cs, bus.spi_sclk}), 64'(3'b111));
        #1 reset_n = 1'b0;
        #1 check("async_reset_outputs", 64'({bus.busy, bus.done, bus.data_valid, bus.data_out,
                                             bus.spi_cs, bus.spi_sclk, bus.spi_mosi}), 64'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        run_row(vecs[0], "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
